// File: rtl/simplez_pkg.sv
// -----------------------------------------------------------------------------
// simplez_pkg
// Shared widths, opcode encodings and the FSM state type for the Simplez core.
// Instruction word layout: [11:9] opcode (CO), [8:0] address field (CD).
// -----------------------------------------------------------------------------
package simplez_pkg;

  localparam int WORD_W = 12;
  localparam int ADDR_W = 9;
  localparam int OP_W   = 3;

  typedef logic [OP_W-1:0]   opcode_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam opcode_t OP_ST   = 3'o0;
  localparam opcode_t OP_LD   = 3'o1;
  localparam opcode_t OP_ADD  = 3'o2;
  localparam opcode_t OP_BR   = 3'o3;
  localparam opcode_t OP_BZ   = 3'o4;
  localparam opcode_t OP_CLR  = 3'o5;
  localparam opcode_t OP_DEC  = 3'o6;
  localparam opcode_t OP_HALT = 3'o7;

  // WAIT is only reachable when single-stepping is built in.
  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2,
    WAIT   = 2'd3
  } state_t;

  function automatic opcode_t op_of(input word_t w);
    return w[WORD_W-1 -: OP_W];
  endfunction

  function automatic addr_t cd_of(input word_t w);
    return w[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/simplez_alu.sv
// -----------------------------------------------------------------------------
// simplez_alu
// Combinational accumulator update for the instructions that write AC.
// Ports:
//   i_op      opcode of the instruction being executed
//   i_ac      current accumulator
//   i_operand memory word addressed by CD
//   o_ac      new accumulator value (LD/ADD/CLR/DEC); AC passes through otherwise
//   o_zero    1 when o_ac is zero
// All arithmetic wraps modulo 2^12.
// -----------------------------------------------------------------------------
module simplez_alu
  import simplez_pkg::*;
(
  input  opcode_t           i_op,
  input  logic [WORD_W-1:0] i_ac,
  input  logic [WORD_W-1:0] i_operand,
  output logic [WORD_W-1:0] o_ac,
  output logic              o_zero
);

  always_comb begin
    // NOTE: assign a default before the case so every path drives o_ac;
    // a missing branch would otherwise infer a latch.
    o_ac = i_ac;
    case (i_op)
      OP_LD:   o_ac = i_operand;
      OP_ADD:  o_ac = i_ac + i_operand;
      OP_CLR:  o_ac = '0;
      OP_DEC:  o_ac = i_ac - WORD_W'(1);
      default: o_ac = i_ac;
    endcase
  end

  assign o_zero = (o_ac == '0);

endmodule

// File: rtl/simplez_cpu.sv
// -----------------------------------------------------------------------------
// simplez_cpu
// Simplez accumulator machine: two cycles per instruction (FETCH, EXEC) against
// a memory that registers reads and commits writes on the falling clock edge.
// Ports:
//   clk          system clock, CPU state changes on posedge
//   rst          asynchronous active-high reset
//   i_step       single-step request (only with SIMPLEZ_STEP_EN)
//   o_mem_addr   memory address (PC in FETCH/HALTED/WAIT, CD in EXEC)
//   o_mem_wr     memory write enable (EXEC of ST only)
//   o_mem_wdata  write data, always the accumulator
//   i_mem_rdata  memory read data, registered by memory at negedge
//   o_ac         accumulator
//   o_zf         zero flag
//   o_halt       high while halted
// Build option: define SIMPLEZ_STEP_EN to add i_step and the WAIT state, which
// parks the core after every EXEC until a rising edge on i_step.
// -----------------------------------------------------------------------------
module simplez_cpu
  import simplez_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
`ifdef SIMPLEZ_STEP_EN
  input  logic              i_step,
`endif
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wr,
  output logic [WORD_W-1:0] o_mem_wdata,
  input  logic [WORD_W-1:0] i_mem_rdata,
  output logic [WORD_W-1:0] o_ac,
  output logic              o_zf,
  output logic              o_halt
);

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [WORD_W-1:0]   r_ac;
  logic                r_zf;
  logic [WORD_W-1:0]   r_ir;

  opcode_t             w_op;
  logic [ADDR_W-1:0]   w_cd;
  opcode_t             w_fetch_op;
  logic [WORD_W-1:0]   w_alu_ac;
  logic                w_alu_zero;

  assign w_op       = op_of(r_ir);
  assign w_cd       = cd_of(r_ir);
  // Opcode of the word arriving this FETCH, so HALT is recognised without an EXEC.
  assign w_fetch_op = op_of(i_mem_rdata);

`ifdef SIMPLEZ_STEP_EN
  logic r_step_d;
  logic w_step_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_step_d <= 1'b0;
    else     r_step_d <= i_step;
  end

  // A held-high step produces one rise only, so it releases one instruction.
  assign w_step_rise = i_step & ~r_step_d;
`endif

  simplez_alu u_alu (
    .i_op      (w_op),
    .i_ac      (r_ac),
    .i_operand (i_mem_rdata),
    .o_ac      (w_alu_ac),
    .o_zero    (w_alu_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) r_state <= FETCH;
    else     r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FETCH:  w_next_state = (w_fetch_op == OP_HALT) ? HALTED : EXEC;
`ifdef SIMPLEZ_STEP_EN
      EXEC:   w_next_state = WAIT;
      WAIT:   w_next_state = w_step_rise ? FETCH : WAIT;
`else
      EXEC:   w_next_state = FETCH;
`endif
      HALTED: w_next_state = HALTED;
      default: w_next_state = FETCH;
    endcase
  end

  // Memory-side outputs; a reset drops r_state to FETCH at once, so o_mem_wr
  // falls before the memory's next negedge.
  always_comb begin
    o_mem_addr  = r_pc;
    o_mem_wr    = 1'b0;
    o_mem_wdata = r_ac;
    if (r_state == EXEC) begin
      o_mem_addr = w_cd;
      o_mem_wr   = (w_op == OP_ST);
    end
  end

  assign o_halt = (r_state == HALTED);
  assign o_ac   = r_ac;
  assign o_zf   = r_zf;

  // Datapath: IR and PC+1 at the FETCH edge, AC/zf/branch target at EXEC edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= '0;
      r_ac <= '0;
      r_zf <= 1'b0;
      r_ir <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          r_ir <= i_mem_rdata;
          r_pc <= r_pc + ADDR_W'(1);
        end
        EXEC: begin
          case (w_op)
            OP_BR: r_pc <= w_cd;
            OP_BZ: if (r_zf) r_pc <= w_cd;
            OP_LD, OP_ADD, OP_CLR, OP_DEC: begin
              r_ac <= w_alu_ac;
              r_zf <= w_alu_zero;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/simplez_cpu.md
# simplez_cpu

Simplez processor core: 12-bit accumulator machine that drives the 512×12 program/data memory directly upstream of it. Fetches instructions, decodes the 3-bit opcode and 9-bit address field, executes the eight Simplez instructions and issues memory reads and writes. Two clock cycles per instruction, timed against the memory's negedge-registered read and write port.

## Interface
- No parameters. Widths are fixed by the shared package: word 12, address 9, opcode 3.
- `clk` in 1: system clock. CPU state updates on posedge; memory samples on negedge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_addr` out 9: memory address.
- `mem_wr` out 1: memory write enable.
- `mem_wdata` out 12: write data, connected to memory `data_in`.
- `mem_rdata` in 12: memory `data_out`, registered by memory at the negedge.
- `ac` out 12: accumulator, for observation.
- `zf` out 1: zero flag.
- `halt` out 1: high while halted.
- `step` in 1: present only with `SIMPLEZ_STEP_EN` (see Configuration).

## Operation
- Instruction format: `[11:9]` CO, `[8:0]` CD.
- Opcodes (octal):
  - 0 ST: mem[CD] ← AC
  - 1 LD: AC ← mem[CD]
  - 2 ADD: AC ← AC + mem[CD]
  - 3 BR: PC ← CD
  - 4 BZ: PC ← CD if zf
  - 5 CLR: AC ← 0
  - 6 DEC: AC ← AC − 1
  - 7 HALT
- States and transitions:
  - FETCH: mem_addr=PC. At posedge, IR ← mem_rdata and PC ← PC+1; go to EXEC, or to HALTED if the opcode is 7.
  - EXEC: mem_addr=CD; mem_wr=1 only for ST; mem_wdata=AC always. At posedge, complete the instruction and go to FETCH.
  - HALTED: mem_addr=PC, mem_wr=0. The block stays here until `rst`.
- Arithmetic and flags:
  - All arithmetic is modulo 2^12: 7777+1=0000; DEC of 0000 gives 7777.
  - PC is modulo 2^9: 777+1=000.
  - LD, ADD, CLR and DEC set zf=(new AC==0). ST, BR, BZ and HALT leave zf unchanged.
  - A branch taken in EXEC overrides the PC+1 done in FETCH.
- Memory interface outputs (`mem_addr`, `mem_wr`, `mem_wdata`) are combinational from state, IR, PC and AC. They are stable from posedge through the following negedge.

## Timing
- Reset values: PC=000, AC=0000, zf=0, IR=0000, state FETCH.
  - Resulting outputs: mem_addr=000, mem_wr=0, halt=0, ac=0000.
- Read latency:
  - Address is driven during a cycle.
  - Memory registers the data at that cycle's negedge.
  - CPU captures it at the next posedge, so data is usable in the same cycle.
- Writes: mem_wr is high for exactly one cycle (EXEC of ST). Memory commits at that cycle's negedge.
- Cycle counts: every instruction takes 2 cycles. HALT asserts `halt` at the end of its FETCH cycle.
- Reset mid-operation:
  - `rst` forces FETCH asynchronously, so mem_wr falls immediately.
  - A write whose negedge already occurred stays committed.
  - After release, the first fetch is from address 000 on the next cycle.
- No instruction is partially retired: AC, zf and PC update only at the EXEC posedge; IR and PC+1 update at the FETCH posedge.

## Configuration
- `SIMPLEZ_STEP_EN` defined:
  - Adds input `step` and a state WAIT.
  - After every EXEC, the CPU enters WAIT with mem_wr=0.
  - A rising edge of `step` (sampled with a 1-cycle registered edge detector) moves the CPU to FETCH on the following posedge.
  - `step` held high advances exactly one instruction.
  - Reset leaves the CPU in FETCH, so the first instruction runs without a step.
- Undefined: no `step` port and no WAIT state; free-running at 2 cycles per instruction.

## Structure
- `simplez_pkg` holds:
  - Width constants `WORD_W`=12, `ADDR_W`=9.
  - Opcode constants `OP_ST` … `OP_HALT`.
  - State enum FETCH/EXEC/HALTED/WAIT.
- One sub-module, `simplez_alu`: combinational. Inputs opcode, AC, operand; outputs new AC and the zero result. Covers LD/ADD/CLR/DEC.
- The FSM and registers live in `simplez_cpu`.

## Test plan
- Default memory image (mem[0]=1006, mem[1]=0100, mem[2]=7000, mem[6]=0005), release reset:
  - mem_wr high only in cycle 4, with addr 0100 and wdata 0005.
  - `halt` rises at the posedge ending cycle 5.
  - ac=0005, zf=0.
- LD of 7777 then ADD of 0001:
  - ac=0000, zf=1.
  - A following BZ 0040 takes the next fetch from 040.
- CLR, DEC:
  - ac=7777, zf=0.
  - A following BZ 0040 is not taken; the next fetch address is the BZ address+1.
- BR 0777 with a CLR at 777: the fetch after CLR is at 000 (PC wrap).
- `rst` pulse during EXEC of ST:
  - mem_wr drops combinationally before the negedge; memory is unchanged.
  - Fetch resumes at 000.
- With `SIMPLEZ_STEP_EN`, three `step` pulses:
  - Exactly three instructions retire after the first.
  - mem_addr and ac hold constant while in WAIT.
